pic_ack_master: RTL
===================

// Module: pic_ack_master
// PURPOSE
//  CPU-side counterpart of the PIC-lite interrupt controller. After reset it programs the PIC
//  over the 16-bit data_m bus: ICW1, ICW2, ICW4, then the enable mask. It then accepts the
//  PIC's intr/irq request, issues the one-cycle inta acknowledge and hands the vector to the
//  core with a valid/ready handshake. It also issues non-specific or specific EOI writes on
//  request from the core.
// PARAMETERS
//  VECTOR_BASE  8'h08  vector base; bits [7:3] are written as ICW2, bits [2:0] are ignored
//  ICW4_VAL     8'h01  byte written as ICW4
//  IRQ_ENABLE   8'hFF  initial mask; bit=1 enables that line (PIC gates edges with mask & edge)
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, asynchronous, active-high
//  pic_cs        out  1   chip select to PIC; high whenever m_access is high
//  m_access      out  1   bus strobe, exactly one cycle per write
//  m_wr_en       out  1   write enable; always 1 when m_access=1
//  m_bytesel     out  2   2'b01 = command byte [7:0]; 2'b10 = data byte [15:8]
//  m_data_out    out  16  write data
//  m_ack         in   1   PIC ack; arrives one cycle after the strobe
//  intr          in   1   PIC interrupt request
//  irq           in   8   PIC vector; valid only while intr=1 and inta=0
//  inta          out  1   interrupt acknowledge pulse to PIC
//  if_flag       in   1   core interrupt-enable flag
//  inst_boundary in   1   core is at an instruction boundary
//  int_valid     out  1   vector available to core
//  int_vector    out  8   vector; stable while int_valid=1
//  int_ready     in   1   core accepts the vector
//  eoi_req       in   1   EOI request; level, held until eoi_done
//  eoi_specific  in   1   1 = specific EOI, 0 = non-specific
//  eoi_level     in   3   ISR bit cleared by a specific EOI
//  eoi_done      out  1   one-cycle pulse when the EOI write has been acked
//  init_done     out  1   high once PIC programming is complete
// BEHAVIOUR
//  Reset (async) values
//   - All outputs 0. FSM enters INIT_ICW1.
//   - Reset mid-operation abandons any write, acknowledge or delivery in progress and
//     restarts initialisation.
//  Bus writes (each write is a strobe/ack pair)
//   - m_access is high for exactly 1 cycle, then low while waiting for m_ack. The PIC acts on
//     every cycle access is high, so holding the strobe would double-step ICWs or clear two ISR bits.
//   - The next strobe is issued no earlier than the cycle after m_ack.
//  Init sequence (states INIT_ICW1 -> INIT_ICW2 -> INIT_ICW4 -> INIT_MASK -> IDLE)
//   - INIT_ICW1: bytesel 01, data 16'h0013
//   - INIT_ICW2: bytesel 10, data {VECTOR_BASE[7:3],3'b0,8'h00}
//   - INIT_ICW4: bytesel 10, data {ICW4_VAL,8'h00}
//   - INIT_MASK: bytesel 10, data {IRQ_ENABLE,8'h00}
//   - init_done rises on the cycle IDLE is entered and stays high until reset.
//   - intr and eoi_req are ignored until init_done=1.
//  IDLE priority
//   - eoi_req beats interrupt acceptance, so a pending EOI unblocks lower-priority lines first.
//  Acceptance timing
//   - Cycle T (IDLE): intr & if_flag & inst_boundary & !eoi_req. Latch irq into vec_q.
//   - T+1 (INTA): inta=1 for exactly one cycle.
//   - T+2 (DELIVER): int_valid=1, int_vector=vec_q.
//   - Stay in DELIVER until int_valid & int_ready, then return to IDLE the next cycle.
//   - No new inta while in DELIVER. intr may drop at T+1 without effect.
//  EOI (state EOI_WR)
//   - Non-specific: bytesel 01, data 16'h0020.
//   - Specific: bytesel 01, data {8'h00,5'b01100,eoi_level}.
//   - eoi_level and eoi_specific are sampled at the strobe.
//   - eoi_done pulses the cycle m_ack is seen; return to IDLE.
//   - The core must drop eoi_req after eoi_done; a still-high eoi_req is treated as a new request.
// STRUCTURE
//  - Package pic_pkg:
//    - state enum
//    - ICW1 constant 8'h13
//    - OCW2 constants EOI_NONSPEC 3'b001 and EOI_SPEC 3'b011
//    - byte-select constants BSEL_CMD and BSEL_DATA
//  - Sub-module pic_bus_writer:
//    - inputs: start, bytesel, data
//    - outputs: the one-cycle strobe, busy, done (on m_ack)
//    - shared by the init and EOI paths.
// TESTING
//  - Reset release with pic model attached:
//    - 4 strobes: 01/0013, 10/0800, 10/0100, 10/FF00, each 1 cycle wide.
//    - init_done=1 after 4th ack; PIC reaches idle.
//  - Accept an interrupt:
//    - Raise intr_in[3] with if_flag=1 and inst_boundary=1.
//    - inta pulses once; int_valid shows vector 8'h0B.
//    - Hold int_ready=0 for 5 cycles: vector stays stable, no 2nd inta.
//  - if_flag=0 with intr pending: no inta for 20 cycles. Set if_flag=1: inta next boundary cycle.
//  - EOI writes:
//    - eoi_req, eoi_specific=0: strobe 01/0020, eoi_done 1 cycle, PIC ISR bit 3 clears.
//    - Specific with level 5: data 0065.
//  - eoi_req and an acceptable intr in the same IDLE cycle: EOI write first, inta only afterwards.
//  - Reset asserted during INIT_ICW4 wait, and again during DELIVER:
//    - All outputs 0 immediately.
//    - Init restarts from ICW1; the previous vector is never delivered.

Source files
------------

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared types and constants for the CPU-side PIC-lite master.
//   state_t      : controller FSM states (init writes, idle, acknowledge,
//                  delivery, EOI write)
//   ICW1         : fixed first initialisation command byte
//   EOI_NONSPEC  : OCW2 top bits for a non-specific EOI
//   EOI_SPEC     : OCW2 top bits for a specific EOI
//   BSEL_CMD     : byte-select for the command byte [7:0]
//   BSEL_DATA    : byte-select for the data byte [15:8]
//   ocw2_word()  : builds the 16-bit EOI write word
// ---------------------------------------------------------------------------
package pic_pkg;

  typedef enum logic [2:0] {
    INIT_ICW1,
    INIT_ICW2,
    INIT_ICW4,
    INIT_MASK,
    IDLE,
    INTA,
    DELIVER,
    EOI_WR
  } state_t;

  localparam logic [7:0] ICW1        = 8'h13;
  localparam logic [2:0] EOI_NONSPEC = 3'b001;
  localparam logic [2:0] EOI_SPEC    = 3'b011;
  localparam logic [1:0] BSEL_CMD    = 2'b01;
  localparam logic [1:0] BSEL_DATA   = 2'b10;

  // OCW2 lives in the command byte; the level field only matters for a
  // specific EOI.
  function automatic logic [15:0] ocw2_word(input logic       specific,
                                            input logic [2:0] level);
    if (specific)
      ocw2_word = {8'h00, EOI_SPEC, 2'b00, level};
    else
      ocw2_word = {8'h00, EOI_NONSPEC, 5'b00000};
  endfunction

endpackage

// File: rtl/pic_bus_writer.sv
// ---------------------------------------------------------------------------
// pic_bus_writer
// Issues one PIC bus write as a single-cycle strobe and waits for its ack.
// Shared by the initialisation sequence and the EOI path.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : request a write (taken only when not busy)
//   bytesel     : byte-select for the write
//   data        : write data
//   m_access    : bus strobe, high for exactly one cycle per write
//   m_bytesel   : registered byte-select
//   m_data_out  : registered write data
//   m_ack       : PIC acknowledge, one cycle after the strobe
//   busy        : a write is outstanding
//   done        : the ack for the outstanding write is present this cycle
// ---------------------------------------------------------------------------
module pic_bus_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  bytesel,
  input  logic [15:0] data,
  output logic        m_access,
  output logic [1:0]  m_bytesel,
  output logic [15:0] m_data_out,
  input  logic        m_ack,
  output logic        busy,
  output logic        done
);

  // The PIC acts on every cycle the strobe is high, so the strobe is a
  // pulse and the ack is only honoured once the strobe has dropped.
  assign done = busy && !m_access && m_ack;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_access   <= 1'b0;
      m_bytesel  <= 2'b00;
      m_data_out <= 16'h0000;
      busy       <= 1'b0;
    end else begin
      m_access <= 1'b0;
      if (start && !busy) begin
        m_access   <= 1'b1;
        m_bytesel  <= bytesel;
        m_data_out <= data;
        busy       <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pic_ack_master.sv
// ---------------------------------------------------------------------------
// pic_ack_master
// CPU-side master for the PIC-lite controller. Programs the PIC after reset
// (ICW1, ICW2, ICW4, mask), then acknowledges interrupts, hands the vector
// to the core over a valid/ready handshake, and issues EOI writes.
//   clk, reset    : clock, asynchronous active-high reset
//   pic_cs        : PIC chip select, mirrors m_access
//   m_access      : one-cycle bus strobe per write
//   m_wr_en       : write enable, mirrors m_access
//   m_bytesel     : 01 = command byte, 10 = data byte
//   m_data_out    : write data
//   m_ack         : PIC ack, one cycle after the strobe
//   intr, irq     : PIC request and vector (vector valid while intr & !inta)
//   inta          : one-cycle interrupt acknowledge
//   if_flag       : core interrupt enable
//   inst_boundary : core is at an instruction boundary
//   int_valid     : vector available to the core
//   int_vector    : vector, stable while int_valid
//   int_ready     : core accepts the vector
//   eoi_req       : EOI request level, held until eoi_done
//   eoi_specific  : 1 = specific EOI, 0 = non-specific
//   eoi_level     : ISR level cleared by a specific EOI
//   eoi_done      : high in the cycle the EOI write is acked
//   init_done     : high once the PIC is programmed
// ---------------------------------------------------------------------------
module pic_ack_master
  import pic_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE = 8'h08,
  parameter logic [7:0] ICW4_VAL    = 8'h01,
  parameter logic [7:0] IRQ_ENABLE  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pic_cs,
  output logic        m_access,
  output logic        m_wr_en,
  output logic [1:0]  m_bytesel,
  output logic [15:0] m_data_out,
  input  logic        m_ack,
  input  logic        intr,
  input  logic [7:0]  irq,
  output logic        inta,
  input  logic        if_flag,
  input  logic        inst_boundary,
  output logic        int_valid,
  output logic [7:0]  int_vector,
  input  logic        int_ready,
  input  logic        eoi_req,
  input  logic        eoi_specific,
  input  logic [2:0]  eoi_level,
  output logic        eoi_done,
  output logic        init_done
);

  state_t      state;
  logic        wr_sent;
  logic        wr_start;
  logic        wr_busy;
  logic        wr_done;
  logic        write_state;
  logic [1:0]  wr_bytesel;
  logic [15:0] wr_data;
  logic [7:0]  vec_q;

  assign pic_cs  = m_access;
  assign m_wr_en = m_access;

  assign write_state = (state == INIT_ICW1) || (state == INIT_ICW2) ||
                       (state == INIT_ICW4) || (state == INIT_MASK) ||
                       (state == EOI_WR);

  // wr_sent keeps each write state to exactly one write; it is cleared on
  // the ack together with the state advance.
  assign wr_start = write_state && !wr_sent && !wr_busy;

  // The core drops eoi_req on seeing this, so it must be visible in the ack
  // cycle rather than a cycle later in IDLE, where a still-high request
  // would start another EOI.
  assign eoi_done = (state == EOI_WR) && wr_done;

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    wr_bytesel = BSEL_DATA;
    wr_data    = 16'h0000;
    case (state)
      INIT_ICW1: begin
        wr_bytesel = BSEL_CMD;
        wr_data    = {8'h00, ICW1};
      end
      INIT_ICW2: wr_data = {VECTOR_BASE[7:3], 3'b000, 8'h00};
      INIT_ICW4: wr_data = {ICW4_VAL, 8'h00};
      INIT_MASK: wr_data = {IRQ_ENABLE, 8'h00};
      EOI_WR: begin
        wr_bytesel = BSEL_CMD;
        wr_data    = ocw2_word(eoi_specific, eoi_level);
      end
      default: ;
    endcase
  end

  pic_bus_writer u_writer (
    .clk        (clk),
    .reset      (reset),
    .start      (wr_start),
    .bytesel    (wr_bytesel),
    .data       (wr_data),
    .m_access   (m_access),
    .m_bytesel  (m_bytesel),
    .m_data_out (m_data_out),
    .m_ack      (m_ack),
    .busy       (wr_busy),
    .done       (wr_done)
  );

  // NOTE: vec_q is reset along with the control flops; it is a single
  // register, and a reset mid-delivery must not leave a stale vector around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT_ICW1;
      wr_sent    <= 1'b0;
      vec_q      <= 8'h00;
      inta       <= 1'b0;
      int_valid  <= 1'b0;
      int_vector <= 8'h00;
      init_done  <= 1'b0;
    end else begin
      inta <= 1'b0;
      if (wr_start) wr_sent <= 1'b1;
      if (wr_done)  wr_sent <= 1'b0;

      case (state)
        INIT_ICW1: if (wr_done) state <= INIT_ICW2;
        INIT_ICW2: if (wr_done) state <= INIT_ICW4;
        INIT_ICW4: if (wr_done) state <= INIT_MASK;
        INIT_MASK: begin
          if (wr_done) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          // A pending EOI goes first so lower-priority lines get unblocked.
          if (eoi_req) begin
            state <= EOI_WR;
          end else if (intr && if_flag && inst_boundary) begin
            vec_q <= irq;
            inta  <= 1'b1;
            state <= INTA;
          end
        end
        INTA: begin
          int_valid  <= 1'b1;
          int_vector <= vec_q;
          state      <= DELIVER;
        end
        DELIVER: begin
          if (int_ready) begin
            int_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        EOI_WR:  if (wr_done) state <= IDLE;
        default: state <= INIT_ICW1;
      endcase
    end
  end

endmodule
